// File: rtl/pop_ui_pkg.sv
// ============================================================================
// Module      : pop_ui_pkg
// Description : Shared types and timing constants for the panel UI front end.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package pop_ui_pkg;

    localparam int unsigned CLK_HZ        = 2_500_000;
    localparam int unsigned DEBOUNCE_20MS = CLK_HZ / 50;
    localparam int unsigned LONG_PRESS_1S = CLK_HZ;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        DEB_PRESS   = 2'd1,
        HELD        = 2'd2,
        DEB_RELEASE = 2'd3
    } btn_state_e;

endpackage

`default_nettype wire

// File: rtl/sync_chain.sv
// ============================================================================
// Module      : sync_chain
// Description : Multi-flop synchroniser for an asynchronous level, resets to 1.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sync_chain #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// Module      : button_conditioner
// Description : Synchronise/debounce an active-low button; press, release and
//               long-press strobes plus a 2-bit step index with one-hot decode.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module button_conditioner
    import pop_ui_pkg::*;
#(
    parameter int unsigned SYNC_STAGES       = 2,
    parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_20MS,
    parameter int unsigned LONG_PRESS_CYCLES = LONG_PRESS_1S
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       button_n,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [1:0] step,
    output logic [3:0] step_onehot
);

    localparam int unsigned CW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_PRESS_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic          s_w;
    btn_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc_w;
    logic          long_done_q, long_done_d;
    logic          pressed_q, pressed_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic [1:0]    step_q, step_d;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (button_n),
        .q_o (s_w)
    );

    assign cnt_inc_w = cnt_q + CNT_ONE;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        long_done_d = long_done_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        case (state_q)
            IDLE: begin
                long_done_d = 1'b0;
                if (!s_w) begin
                    state_d = DEB_PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            DEB_PRESS: begin
                if (s_w) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc_w;
                end
            end
            HELD: begin
                if (s_w) begin
                    state_d = DEB_RELEASE;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q != LONG_LAST) begin
                    cnt_d = cnt_inc_w;
                    // long_done survives release bounces so one press yields one long strobe
                    if (cnt_inc_w == LONG_LAST && !long_done_q) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end
                end
            end
            DEB_RELEASE: begin
                if (!s_w) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc_w;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        pressed_d = (state_d == HELD) || (state_d == DEB_RELEASE);
    end

    always_comb begin
        step_d = step_q;
        if (long_q) begin
            step_d = 2'd0;
        end else if (press_q) begin
            step_d = step_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            long_done_q <= 1'b0;
            pressed_q   <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            step_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            long_done_q <= long_done_d;
            pressed_q   <= pressed_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            step_q      <= step_d;
        end
    end

    assign pressed       = pressed_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign step          = step_q;
    assign step_onehot   = 4'b0001 << step_q;

endmodule

`default_nettype wire
